// File: rtl/lfsr_pkg.sv
// Shared constants for the parametrised LFSR generator: structure select
// encodings and default maximal-length polynomials for common widths.
package lfsr_pkg;

    // Structure select, sampled on every step
    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

    // 4-bit defaults: x^4 + x^3 + 1 (Fibonacci), x^4 + x + 1 (Galois)
    localparam logic [3:0]  DEF_TAPS_4  = 4'hC;
    localparam logic [3:0]  DEF_GMASK_4 = 4'h3;
    localparam logic [3:0]  DEF_SEED_4  = 4'h1;

    // 8-bit defaults: x^8 + x^6 + x^5 + x^4 + 1 / x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [7:0]  DEF_TAPS_8  = 8'hB8;
    localparam logic [7:0]  DEF_GMASK_8 = 8'h1D;
    localparam logic [7:0]  DEF_SEED_8  = 8'h01;

    // 16-bit defaults, compatible with the fixed 16-bit predecessor
    localparam logic [15:0] DEF_TAPS_16  = 16'hB400;
    localparam logic [15:0] DEF_GMASK_16 = 16'h6801;
    localparam logic [15:0] DEF_SEED_16  = 16'h0001;

endpackage

// File: rtl/lfsr_next.sv
// Purely combinational next-state function of the LFSR. Both structures
// shift towards the MSB; Fibonacci feeds the tap parity into bit 0, Galois
// folds the mask in whenever the outgoing MSB is set.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS_16),
    parameter logic [WIDTH-1:0] GMASK = WIDTH'(DEF_GMASK_16)
) (
    input  logic [WIDTH-1:0] state,
    input  logic             mode,
    output logic [WIDTH-1:0] next
);

    logic             fib_fb;
    logic [WIDTH-1:0] shifted;

    // Select Fibonacci or Galois successor of the current state
    always_comb begin
        fib_fb  = ^(state & TAPS);
        shifted = {state[WIDTH-2:0], 1'b0};
        next    = shifted;
        if (mode == MODE_FIB) begin
            next = {state[WIDTH-2:0], fib_fb};
        end else if (state[WIDTH-1]) begin
            next = shifted ^ GMASK;
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with runtime seed load, all-zero lock-up
// recovery, a step counter and period/wrap detection.
//
// Control is level-based, no handshake: each rising edge applies exactly
// one action with priority load > lock-up recovery > step > hold.
// wrap and lockup are single-cycle pulses registered together with lfsr.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS_16),
    parameter logic [WIDTH-1:0] GMASK = WIDTH'(DEF_GMASK_16),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED_16)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr,
    output logic             sout,
    output logic [WIDTH-1:0] step_cnt,
    output logic [WIDTH-1:0] period,
    output logic             wrap,
    output logic             lockup
);

    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] next_state;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .GMASK (GMASK)
    ) u_next (
        .state (lfsr_q),
        .mode  (mode),
        .next  (next_state)
    );

    // Prioritised update: load, then lock-up recovery, then step, else hold
    always_comb begin
        lfsr_d     = lfsr_q;
        seed_d     = seed_q;
        step_cnt_d = step_cnt_q;
        period_d   = period_q;
        wrap_d     = 1'b0;
        lockup_d   = 1'b0;
        if (load) begin
            lfsr_d     = seed_in;
            seed_d     = seed_in;
            step_cnt_d = '0;
        end else if (enable && (lfsr_q == '0)) begin
            // Zero is a fixed point of both structures; restart from SEED
            lfsr_d     = SEED;
            seed_d     = SEED;
            step_cnt_d = '0;
            lockup_d   = 1'b1;
        end else if (enable) begin
            lfsr_d = next_state;
            if (next_state == seed_q) begin
                wrap_d     = 1'b1;
                period_d   = step_cnt_q + WIDTH'(1);
                step_cnt_d = '0;
            end else begin
                step_cnt_d = step_cnt_q + WIDTH'(1);
            end
        end
    end

    // State registers with asynchronous reset to the configured seed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q     <= SEED;
            seed_q     <= SEED;
            step_cnt_q <= '0;
            period_q   <= '0;
            wrap_q     <= 1'b0;
            lockup_q   <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            seed_q     <= seed_d;
            step_cnt_q <= step_cnt_d;
            period_q   <= period_d;
            wrap_q     <= wrap_d;
            lockup_q   <= lockup_d;
        end
    end

    assign lfsr     = lfsr_q;
    assign sout     = lfsr_q[WIDTH-1];
    assign step_cnt = step_cnt_q;
    assign period   = period_q;
    assign wrap     = wrap_q;
    assign lockup   = lockup_q;

endmodule
